sevenseg_scan: RTL and testbench

Parametrised N-digit multiplexed seven-segment scan driver, the general successor to the fixed 4-digit display block. It takes packed hex nibbles, per-digit blank and decimal-point masks, and scans the digits from an internal tick divider. New data is double-buffered and only swapped in at frame boundaries, so the display never tears mid-frame. It sits between the datapath/status logic and the board's common-anode display pins.

---
 rtl/sevenseg_scan.sv | 127 ++++++++++++
 tb/tb_sevenseg_scan.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// N-digit multiplexed common-anode seven-segment scanner.
// Digit data is double-buffered and swapped in only at frame boundaries.
module sevenseg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000,
  parameter int GAP        = 1
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int SLOTS = NUM_DIGITS + GAP;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int DW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [DW-1:0] DIV_TOP   = DW'(TICK_DIV - 1);

  logic [DW-1:0]           div;
  logic [SW-1:0]           slot;
  logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
  logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
  logic                    tick, wrap;
  logic [NUM_DIGITS-1:0]   nxt_an;
  logic [6:0]              nxt_seg;
  logic                    nxt_dp;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (div == DIV_TOP);
  assign wrap = tick && (slot == LAST_SLOT);

  // Slot s shows digit NUM_DIGITS-1-s; slots past the last digit are the gap.
  always_comb begin
    nxt_an  = '1;
    nxt_seg = '1;
    nxt_dp  = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (slot == SW'(NUM_DIGITS - 1 - i)) begin
        nxt_an[i] = 1'b0;
        if (!act_blank[i]) begin
          nxt_seg = decode(act_digits[4*i +: 4]);
          nxt_dp  = ~act_dp[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      slot       <= '0;
      sh_digits  <= '0;
      sh_blank   <= '0;
      sh_dp      <= '0;
      act_digits <= '0;
      act_blank  <= '0;
      act_dp     <= '0;
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        sh_digits <= digits;
        sh_blank  <= blank_mask;
        sh_dp     <= dp_mask;
      end
      if (!enable) begin
        div        <= '0;
        slot       <= '0;
        an         <= '1;
        seg        <= '1;
        dp         <= 1'b1;
        frame_done <= 1'b0;
      end else begin
        frame_done <= wrap;
        if (tick) begin
          div <= '0;
          an  <= nxt_an;
          seg <= nxt_seg;
          dp  <= nxt_dp;
          slot <= wrap ? '0 : slot + 1'b1;
          // A load on the wrap edge bypasses the shadow so it is never lost.
          if (wrap) begin
            act_digits <= load ? digits     : sh_digits;
            act_blank  <= load ? blank_mask : sh_blank;
            act_dp     <= load ? dp_mask    : sh_dp;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: vector table, hand sequences and a random run
// against a slot-arithmetic reference model.
module tb_sevenseg_scan;

  localparam int TD_A = 4;
  localparam int ND_A = 4;
  localparam int SLOTS_A = 5;
  localparam int TD_B = 3;

  localparam logic [6:0] SEGTAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en_a = 1'b0, load_a = 1'b0;
  logic [15:0] digits_a = '0;
  logic [3:0] blank_a = '0, dpm_a = '0;
  logic [3:0] an_a;
  logic [6:0] seg_a;
  logic dp_a, fd_a;
  logic en_b = 1'b0, load_b = 1'b0;
  logic [31:0] digits_b = '0;
  logic [7:0] blank_b = '0, dpm_b = '0;
  logic [7:0] an_b;
  logic [6:0] seg_b;
  logic dp_b, fd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(.NUM_DIGITS(ND_A), .TICK_DIV(TD_A), .GAP(1)) dut_a (
    .clock(clk), .rst_n(rst_n), .enable(en_a), .load(load_a),
    .digits(digits_a), .blank_mask(blank_a), .dp_mask(dpm_a),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a));

  sevenseg_scan #(.NUM_DIGITS(8), .TICK_DIV(TD_B), .GAP(0)) dut_b (
    .clock(clk), .rst_n(rst_n), .enable(en_b), .load(load_b),
    .digits(digits_b), .blank_mask(blank_b), .dp_mask(dpm_b),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: edge k after enable is a tick when k is a multiple of
  // TD_A; that tick shows slot (k/TD_A-1) mod SLOTS_A.
  int k;
  logic [15:0] m_sd, m_ad;
  logic [3:0] m_sb, m_ab, m_sp, m_ap, m_an;
  logic [6:0] m_seg;
  logic m_dp, m_fd;

  always @(posedge clk or negedge rst_n) begin : model
    int s, d;
    logic [15:0] sh;
    if (!rst_n) begin
      k <= 0; m_an <= 4'hF; m_seg <= 7'h7F; m_dp <= 1'b1; m_fd <= 1'b0;
      m_sd <= '0; m_sb <= '0; m_sp <= '0; m_ad <= '0; m_ab <= '0; m_ap <= '0;
    end else begin
      if (load_a) begin
        m_sd <= digits_a; m_sb <= blank_a; m_sp <= dpm_a;
      end
      if (!en_a) begin
        k <= 0; m_an <= 4'hF; m_seg <= 7'h7F; m_dp <= 1'b1; m_fd <= 1'b0;
      end else begin
        k <= k + 1;
        m_fd <= 1'b0;
        if ((k + 1) % TD_A == 0) begin
          s = ((k + 1) / TD_A - 1) % SLOTS_A;
          if (s < ND_A) begin
            d = ND_A - 1 - s;
            sh = m_ad >> (4 * d);
            m_an <= 4'hF ^ (4'h1 << d);
            m_seg <= m_ab[d] ? 7'h7F : SEGTAB[sh[3:0]];
            m_dp <= m_ab[d] ? 1'b1 : ~m_ap[d];
          end else begin
            m_an <= 4'hF; m_seg <= 7'h7F; m_dp <= 1'b1;
          end
          if (s == SLOTS_A - 1) begin
            m_fd <= 1'b1;
            m_ad <= load_a ? digits_a : m_sd;
            m_ab <= load_a ? blank_a : m_sb;
            m_ap <= load_a ? dpm_a : m_sp;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_an", an_a, m_an);
    chk("model_seg", seg_a, m_seg);
    chk("model_dp", dp_a, m_dp);
    chk("model_fd", fd_a, m_fd);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_fd(input bit sel, input string name);
    int n = 0;
    do begin step(1); n++; end while (((sel ? fd_b : fd_a) !== 1'b1) && n < 100);
    chk(name, sel ? fd_b : fd_a, 1);
  endtask

  task automatic fd_period(input bit sel, input int exp, input string name);
    int n = 0;
    do begin step(1); n++; end while (((sel ? fd_b : fd_a) !== 1'b1) && n < 200);
    chk(name, n, exp);
  endtask

  // Starts just after a frame boundary of dut_a and ends on the next one.
  task automatic check_frame_a(input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] ea;
    for (int s = 0; s < 4; s++) begin
      step(TD_A);
      ea = ~(4'b1000 >> s);
      chk("scan_an", an_a, ea);
      chk("scan_seg", seg_a, segs[7*(3-s) +: 7]);
      chk("scan_dp", dp_a, dps[3-s]);
      chk("scan_fd", fd_a, 0);
    end
    step(TD_A);
    chk("gap_an", an_a, 4'hF);
    chk("gap_seg", seg_a, 7'h7F);
    chk("gap_dp", dp_a, 1);
    chk("gap_fd", fd_a, 1);
  endtask

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  blank;
    logic [3:0]  dpm;
    logic [27:0] segs;
    logic [3:0]  dps;
  } vec_t;

  task automatic apply_vec(input vec_t v);
    digits_a = v.dig; blank_a = v.blank; dpm_a = v.dpm; load_a = 1'b1;
    step(1);
    load_a = 1'b0;
    wait_fd(0, "vec_swap");
    check_frame_a(v.segs, v.dps);
  endtask

  vec_t vecs [5];

  initial begin
    logic [7:0] eb;
    vecs[0] = '{16'h7608, 4'b0000, 4'b0000,
                {7'b1111000, 7'b0000010, 7'b1000000, 7'b0000000}, 4'b1111};
    vecs[1] = '{16'hABCF, 4'b0100, 4'b0001,
                {7'b0001000, 7'h7F, 7'b1000110, 7'b0001110}, 4'b1110};
    vecs[2] = '{16'h1111, 4'b0000, 4'b0000, {4{7'b1111001}}, 4'b1111};
    vecs[3] = '{16'h3E9D, 4'b0000, 4'b1010,
                {7'b0110000, 7'b0000110, 7'b0010000, 7'b0100001}, 4'b0101};
    vecs[4] = '{16'h45B2, 4'b1001, 4'b1111,
                {7'h7F, 7'b0010010, 7'b0000011, 7'h7F}, 4'b1001};

    #2 rst_n = 1'b0;
    #2;
    chk("rst_an", an_a, 4'hF);
    chk("rst_seg", seg_a, 7'h7F);
    chk("rst_dp", dp_a, 1);
    chk("rst_fd", fd_a, 0);
    chk("rst_an_b", an_b, 8'hFF);
    step(2);
    rst_n = 1'b1;

    // Eight digits, no gap slot.
    digits_b = 32'h01234567; load_b = 1'b1; en_b = 1'b1;
    step(1);
    load_b = 1'b0;
    wait_fd(1, "b_swap");
    for (int s = 0; s < 8; s++) begin
      step(TD_B);
      eb = ~(8'h80 >> s);
      chk("b_an", an_b, eb);
      chk("b_seg", seg_b, SEGTAB[s]);
      chk("b_dp", dp_b, 1);
    end
    chk("b_wrap_fd", fd_b, 1);
    fd_period(1, 8 * TD_B, "b_fd_period");
    en_b = 1'b0;

    en_a = 1'b1;
    for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

    apply_vec(vecs[0]);
    fd_period(0, 5 * TD_A, "a_fd_period");
    // Mid-frame load must not disturb the rest of the frame.
    step(2 * TD_A);
    digits_a = 16'h1111; blank_a = '0; dpm_a = '0; load_a = 1'b1;
    step(1);
    load_a = 1'b0;
    step(TD_A - 1);
    chk("tear_seg2", seg_a, 7'b1000000);
    chk("tear_an2", an_a, 4'b1101);
    step(TD_A);
    chk("tear_seg3", seg_a, 7'b0000000);
    step(TD_A);
    chk("tear_fd", fd_a, 1);
    check_frame_a({4{7'b1111001}}, 4'b1111);
    // Load exactly on the wrap edge.
    step(5 * TD_A - 1);
    digits_a = 16'h2222; load_a = 1'b1;
    step(1);
    load_a = 1'b0;
    chk("bypass_fd", fd_a, 1);
    check_frame_a({4{7'b0100100}}, 4'b1111);

    step(2);
    en_a = 1'b0;
    step(1);
    chk("dis_an", an_a, 4'hF);
    chk("dis_seg", seg_a, 7'h7F);
    chk("dis_fd", fd_a, 0);
    step(3);
    en_a = 1'b1;
    for (int i = 1; i <= TD_A; i++) begin
      step(1);
      chk("reen_an", an_a, (i < TD_A) ? 4'hF : 4'b0111);
    end
    chk("reen_seg", seg_a, 7'b0100100);

    step(TD_A + 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an_a, 4'hF);
    chk("arst_seg", seg_a, 7'h7F);
    chk("arst_dp", dp_a, 1);
    chk("arst_fd", fd_a, 0);
    step(1);
    rst_n = 1'b1;
    check_frame_a({4{7'b1000000}}, 4'b1111);

    for (int i = 0; i < 600; i++) begin
      en_a = ($urandom_range(0, 19) != 0);
      load_a = ($urandom_range(0, 7) == 0);
      digits_a = 16'($urandom);
      blank_a = 4'($urandom);
      dpm_a = 4'($urandom);
      step(1);
    end
    en_a = 1'b1; load_a = 1'b0;
    step(3 * SLOTS_A * TD_A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
